oka_mul32_seq: RTL and testbench

Sequential 32x32 carry-less (GF(2)[x]) polynomial multiplier. A single shared instance of the combinational 16-bit OKA multiplier is sequenced over three Karatsuba passes: low halves, high halves, then XOR-folded halves. The block sits between an operand producer and a result consumer, each with a valid/ready handshake. It trades throughput for area: one 16-bit core in place of a full 32-bit Karatsuba tree.

---
 rtl/oka_pkg.sv | 28 ++
 rtl/oka_mul32_seq_oka16.sv | 21 ++
 rtl/oka_mul32_seq.sv | 94 +++++++++
 tb/tb_oka_mul32_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/oka_pkg.sv
// Shared types, widths and a small carry-less helper for the sequential
// OKA multiplier and its 16-bit core.
package oka_pkg;

  localparam int OP_W   = 32;
  localparam int HALF_W = 16;
  localparam int PP_W   = 31;
  localparam int PROD_W = 63;

  typedef enum logic [2:0] {
    IDLE,
    Z0,
    Z2,
    Z1,
    DONE
  } state_t;

  // Schoolbook GF(2) product of two 8-bit polynomials; leaf of the 16-bit Karatsuba core.
  function automatic logic [14:0] clmul8(input logic [7:0] x, input logic [7:0] z);
    logic [14:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) r = r ^ ({7'b0, x} << i);
    end
    return r;
  endfunction

endpackage

// File: rtl/oka_mul32_seq_oka16.sv
// Combinational 16x16 carry-less multiplier built as one Karatsuba level
// over three 8x8 schoolbook products.
module OKA_16bit_26
  import oka_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  output logic [PP_W-1:0]   y
);

  logic [14:0] p0, p1, p2, mid;

  assign p0  = clmul8(a[7:0], b[7:0]);
  assign p2  = clmul8(a[15:8], b[15:8]);
  assign p1  = clmul8(a[7:0] ^ a[15:8], b[7:0] ^ b[15:8]);
  // Middle Karatsuba term: cross products recovered from the folded product.
  assign mid = p1 ^ p0 ^ p2;

  assign y = {16'b0, p0} ^ ({16'b0, mid} << 8) ^ ({16'b0, p2} << 16);

endmodule

// File: rtl/oka_mul32_seq.sv
// Sequential 32x32 GF(2)[x] multiplier: one shared 16-bit OKA core stepped
// through low, high and folded Karatsuba passes behind valid/ready handshakes.
module oka_mul32_seq
  import oka_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] y,
  output logic              busy
);

  state_t              state;
  logic [OP_W-1:0]     op_a, op_b;
  logic [PROD_W-1:0]   acc;
  logic [HALF_W-1:0]   core_a, core_b;
  logic [PP_W-1:0]     core_y;
  logic [PROD_W-1:0]   pp;

  // Core operands always come from the latched registers, selected by pass.
  always_comb begin
    core_a = op_a[HALF_W-1:0];
    core_b = op_b[HALF_W-1:0];
    case (state)
      Z2: begin
        core_a = op_a[OP_W-1:HALF_W];
        core_b = op_b[OP_W-1:HALF_W];
      end
      Z1: begin
        core_a = op_a[HALF_W-1:0] ^ op_a[OP_W-1:HALF_W];
        core_b = op_b[HALF_W-1:0] ^ op_b[OP_W-1:HALF_W];
      end
      default: ;
    endcase
  end

  OKA_16bit_26 u_core (
    .a (core_a),
    .b (core_b),
    .y (core_y)
  );

  assign pp       = {{(PROD_W - PP_W){1'b0}}, core_y};
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= b;
            state <= Z0;
          end
        end
        Z0: begin
          acc   <= pp ^ (pp << 16);
          state <= Z2;
        end
        Z2: begin
          acc   <= acc ^ (pp << 16) ^ (pp << 32);
          state <= Z1;
        end
        // Folded pass closes the sum; y is only written here, never from the core directly.
        Z1: begin
          y         <= acc ^ (pp << 16);
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oka_mul32_seq.sv
// Directed and randomized checks of oka_mul32_seq against hand-computed
// products and a bitwise shift-XOR reference.
module tb_oka_mul32_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [62:0] y;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  oka_mul32_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [62:0] refMul(input logic [31:0] x, input logic [31:0] z);
    logic [62:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (z[i]) r = r ^ ({31'b0, x} << i);
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [62:0] observed, input logic [62:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // All tasks start and end 1ns after a rising edge.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv);
    logic got;
    logic accepted;
    int   n;
    accepted = 1'b0;
    n        = 0;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    while (!accepted && n < 50) begin
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (got) accepted = 1'b1;
    end
    in_valid = 1'b0;
    checkOutput("accept", {62'b0, accepted}, 63'd1);
  endtask

  task automatic waitOutput(output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = n;
    checkOutput("out_valid timeout", {62'b0, out_valid}, 63'd1);
  endtask

  task automatic takeOutput();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("out_valid after take", {62'b0, out_valid}, 63'd0);
    checkOutput("in_ready after take", {62'b0, in_ready}, 63'd1);
  endtask

  task automatic runOp(input logic [31:0] av, input logic [31:0] bv, input logic [62:0] expected, input string tag);
    int lat;
    applyStimulus(av, bv);
    waitOutput(lat);
    checkOutput(tag, y, expected);
    takeOutput();
  endtask

  initial begin
    int          lat;
    logic [62:0] held;
    logic [31:0] ra, rb;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1 rst_n  = 1'b0;
    #2;
    checkOutput("reset in_ready", {62'b0, in_ready}, 63'd1);
    checkOutput("reset out_valid", {62'b0, out_valid}, 63'd0);
    checkOutput("reset y", y, 63'd0);
    checkOutput("reset busy", {62'b0, busy}, 63'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1*1 with latency and busy window
    applyStimulus(32'h1, 32'h1);
    checkOutput("busy at k", {62'b0, busy}, 63'd1);
    checkOutput("out_valid at k", {62'b0, out_valid}, 63'd0);
    waitOutput(lat);
    checkOutput("latency", 63'(lat), 63'd3);
    checkOutput("busy at k+3", {62'b0, busy}, 63'd1);
    checkOutput("1*1", y, 63'h1);
    takeOutput();
    checkOutput("busy after take", {62'b0, busy}, 63'd0);

    runOp(32'h00000003, 32'h00000003, 63'h5, "3*3");
    runOp(32'h00000005, 32'h00000003, 63'hF, "5*3");
    runOp(32'hFFFFFFFF, 32'h00000001, 63'hFFFFFFFF, "ffffffff*1");
    runOp(32'h00010000, 32'h00010000, 63'h1_0000_0000, "x16*x16");
    runOp(32'h80000000, 32'h80000000, 63'h4000_0000_0000_0000, "x31*x31");
    runOp(32'hFFFF0000, 32'h00010000, 63'hFFFF_0000_0000, "ffff0000*x16");

    // Backpressure: result must hold and a new offer must be refused
    applyStimulus(32'h00000007, 32'h00000003);
    waitOutput(lat);
    held     = y;
    checkOutput("bp y", held, 63'h9);
    a        = 32'hDEADBEEF;
    b        = 32'h12345678;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp y stable", y, 63'h9);
      checkOutput("bp out_valid", {62'b0, out_valid}, 63'd1);
      checkOutput("bp in_ready", {62'b0, in_ready}, 63'd0);
    end
    in_valid = 1'b0;
    takeOutput();
    checkOutput("bp no stray accept", {62'b0, busy}, 63'd0);

    // Reset while in Z2
    applyStimulus(32'h00000003, 32'h00000005);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", {62'b0, out_valid}, 63'd0);
    checkOutput("midreset y", y, 63'd0);
    checkOutput("midreset in_ready", {62'b0, in_ready}, 63'd1);
    checkOutput("midreset busy", {62'b0, busy}, 63'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checkOutput("midreset no emit", {62'b0, out_valid}, 63'd0);
    runOp(32'h1234ABCD, 32'h00000001, 63'h1234ABCD, "post-reset op");

    // Randomized regression with valid/ready gaps
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(ra, rb);
      waitOutput(lat);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      checkOutput("random y", y, refMul(ra, rb));
      takeOutput();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
